multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle RV32 core. It sits directly upstream of alu_control.
//  Sequences each instruction: FETCH, DECODE, then EXEC/MEM, then writeback.
//  Drives alu_op[1:0] plus all datapath mux/enable strobes.
//  Supports lb, sb, beq and R-type (add/sub/and/or/sll); stalls on memory via mem_ready.
// PARAMETERS
//  MEM_WAIT_MAX  16  consecutive not-ready memory cycles before ERROR; 0 disables timeout
// PORTS
//  clk          in   1  single core clock; all state updates on posedge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   7  IR[6:0]; IR is written only by ir_write, so it is stable after FETCH
//  zero         in   1  ALU zero flag (beq)
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_en        out  1  pc_write | (pc_write_cond & zero)
//  ir_write     out  1  load IR from memory read data
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  i_or_d       out  1  address select: 0=PC, 1=ALUOut
//  reg_write    out  1  register file write enable
//  mem_to_reg   out  1  writeback select: 0=ALUOut, 1=MDR
//  alu_src_a    out  2  00=PC, 01=rs1, 10=oldPC
//  alu_src_b    out  2  00=rs2, 01=const 4, 10=imm
//  alu_op       out  2  to alu_control: 00=add, 01=sub, 10=funct-decoded
//  pc_source    out  1  0=ALU result, 1=ALUOut (branch target)
//  instr_done   out  1  one-cycle pulse on the final cycle of each retired instruction
//  illegal      out  1  one-cycle pulse when DECODE sees an unsupported opcode
//  err          out  1  sticky; memory timeout; cleared only by rst
//  state_o      out  4  current state encoding (debug)
// BEHAVIOUR
//  - Outputs are Moore (decoded from state), except these strobes, which are gated by mem_ready:
//    pc_write/ir_write in FETCH; instr_done in MEM_WRITE.
//  - While rst=1, state<=FETCH and timer<=0, and every output is forced 0 (state_o=FETCH).
//    The first cycle after rst falls is FETCH.
//  - Any output not listed for a state is 0.
//  - FETCH: mem_read=1, i_or_d=0, src_a=00, src_b=01, alu_op=00.
//    On mem_ready: ir_write=1, pc_write=1, pc_source=0, then go to DECODE. Otherwise stay.
//  - DECODE: src_a=10, src_b=10, alu_op=00 (branch target into ALUOut).
//    Next state: LOAD 0000011 or STORE 0100011 -> MEM_ADDR; R 0110011 -> EXECUTE;
//    BRANCH 1100011 -> BRANCH; else illegal=1 and go to FETCH.
//    PC is already +4 when the illegal path returns to FETCH.
//  - MEM_ADDR: src_a=01, src_b=10, alu_op=00. Next is MEM_READ if LOAD, else MEM_WRITE.
//  - MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
//  - MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1, then go to FETCH.
//  - MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready: instr_done=1 and go to FETCH.
//  - EXECUTE: src_a=01, src_b=00, alu_op=10, then go to ALU_WB.
//  - ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1, then go to FETCH.
//  - BRANCH: src_a=01, src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1,
//    then go to FETCH.
//  - Memory timeout timer (FETCH, MEM_READ, MEM_WRITE only):
//    - Counts consecutive cycles in a wait state with mem_ready=0.
//    - Clears on mem_ready=1 or on any state change.
//    - The MEM_WAIT_MAX-th consecutive not-ready cycle moves the FSM to ERROR on the next edge.
//    - mem_ready=1 in that same cycle wins over the timeout: no error.
//  - ERROR: all outputs 0 except err=1. Absorbing until rst.
//  - Undefined state encodings go to ERROR.
//  - Reset mid-instruction (e.g. in MEM_WRITE) aborts it. No strobe is issued in the reset cycle.
//  - pc_en is combinational on zero; it is valid only in FETCH/BRANCH.
// STRUCTURE
//  - riscv_pkg holds: opcode constants, ALU_OP_ADD/SUB/FUNCT, SRC_A_*/SRC_B_* select codes,
//    and the 4-bit state encoding (FETCH=0 ... ERROR=15).
//  - One sub-module: mem_wait_timer (clk, rst, clear, waiting -> expired), parameter MEM_WAIT_MAX.
// TESTING
//  1. R-type: opcode=0110011, mem_ready=1 in FETCH
//     -> states FETCH, DECODE, EXECUTE, ALU_WB; alu_op=10 in EXECUTE; reg_write=1 and
//     instr_done=1 in cycle 4; 4 cycles total.
//  2. lb with mem_ready held 0 for 3 cycles in MEM_READ
//     -> 5 states; MEM_READ lasts 4 cycles; MEM_WB has mem_to_reg=1, reg_write=1.
//  3. beq with zero=1 -> pc_en=1 in BRANCH, alu_op=01.
//     beq with zero=0 -> pc_en=0; instr_done=1 in both cases.
//  4. sb: mem_write=1, i_or_d=1 in MEM_WRITE; reg_write stays 0; instr_done=1 in the ready cycle.
//  5. opcode=1111111 -> illegal pulses 1 cycle in DECODE, then FETCH. err=0.
//  6. MEM_WAIT_MAX=16, mem_ready=0 in FETCH for 16 cycles -> ERROR, err=1 held.
//     Ready arriving in cycle 16 -> no error. Then rst=1 for 1 cycle -> all outputs 0,
//     then FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32 control FSM.
// Opcodes, ALU/mux select codes and the 4-bit state encoding.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ERROR     = 4'd15
  } state_e;

  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM and the datapath.
// master = control FSM, slave = datapath side.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       instr_done;
  logic       illegal;
  logic       err;
  logic [3:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, mem_read,
    output mem_write, i_or_d, reg_write,
    output mem_to_reg, alu_src_a, alu_src_b,
    output alu_op, pc_source, instr_done,
    output illegal, err, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, mem_read,
    input  mem_write, i_or_d, reg_write,
    input  mem_to_reg, alu_src_a, alu_src_b,
    input  alu_op, pc_source, instr_done,
    input  illegal, err, state_o
  );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready memory wait cycles.
// expired flags the MEM_WAIT_MAX-th one; 0 disables.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int W =
    (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [W-1:0] LAST =
    W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [W-1:0] cnt_q, cnt_d;

  // count up while waiting; saturate at the last slot
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !waiting)
      cnt_d = '0;
    else if (cnt_q != LAST)
      cnt_d = cnt_q + W'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (MEM_WAIT_MAX != 0) && waiting &&
                   (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 core.
// Sequences fetch/decode/exec/mem/writeback.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_e state_q, state_d;

  logic waiting, expired, clear;
  logic pc_write, pc_write_cond;
  logic ir_write, mem_read, mem_write;
  logic i_or_d, reg_write, mem_to_reg;
  logic [1:0] src_a, src_b, alu_op;
  logic pc_source, instr_done, illegal, err;

  logic is_load, is_store, is_r, is_br;

  assign is_load  = bus.opcode == OP_LOAD;
  assign is_store = bus.opcode == OP_STORE;
  assign is_r     = bus.opcode == OP_RTYPE;
  assign is_br    = bus.opcode == OP_BRANCH;

  assign waiting = is_mem_wait(state_q) && !bus.mem_ready;
  assign clear   = state_d != state_q;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .waiting (waiting),
    .expired (expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:
        if (is_load || is_store) state_d = S_MEM_ADDR;
        else if (is_r)           state_d = S_EXECUTE;
        else if (is_br)          state_d = S_BRANCH;
        else                     state_d = S_FETCH;
      S_MEM_ADDR:
        state_d = is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:
        if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE:
        if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase
    if (expired) state_d = S_ERROR;
  end

  // Moore strobes; fetch/store handshakes gated by mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    src_a         = SRC_A_PC;
    src_b         = SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    pc_source     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    err           = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          src_b    = SRC_B_FOUR;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          src_a   = SRC_A_OLDPC;
          src_b   = SRC_B_IMM;
          illegal = !(is_load || is_store ||
                      is_r || is_br);
        end
        S_MEM_ADDR: begin
          src_a = SRC_A_RS1;
          src_b = SRC_B_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = bus.mem_ready;
        end
        S_EXECUTE: begin
          src_a  = SRC_A_RS1;
          src_b  = SRC_B_RS2;
          alu_op = ALU_OP_FUNCT;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          src_a         = SRC_A_RS1;
          src_b         = SRC_B_RS2;
          alu_op        = ALU_OP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
          instr_done    = 1'b1;
        end
        S_ERROR: err = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_en      = pc_write |
                          (pc_write_cond & bus.zero);
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.i_or_d     = i_or_d;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_source  = pc_source;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;
  assign bus.err        = err;
  assign bus.state_o    = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Instruction-level generator expands into per-cycle expectations.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int WMAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(
    .MEM_WAIT_MAX(WMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] aop;
    logic       pc_source;
    logic       instr_done;
    logic       illegal;
    logic       err;
  } obs_t;

  typedef struct packed {
    logic       r;
    logic [6:0] op;
    logic       z;
    logic       rdy;
    obs_t       e;
  } cyc_t;

  cyc_t stim[$];
  obs_t scb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_cyc  = 0;
  logic [6:0] cur_op;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic put(logic r, logic [6:0] op,
                     logic z, logic rdy, obs_t e);
    cyc_t c;
    c.r = r; c.op = op; c.z = z; c.rdy = rdy; c.e = e;
    stim.push_back(c);
  endtask

  task automatic reset_cyc();
    put(1'b1, 7'($urandom), rb(), rb(), '0);
  endtask

  task automatic error_tail();
    obs_t e;
    e = blank(S_ERROR);
    e.err = 1'b1;
    repeat (1 + $urandom_range(0, 2))
      put(1'b0, cur_op, rb(), rb(), e);
    reset_cyc();
  endtask

  function automatic obs_t wait_obs(logic [3:0] st,
                                    logic rdy);
    obs_t o;
    o = blank(st);
    if (st == S_FETCH) begin
      o.mem_read = 1'b1;
      o.src_b    = 2'b01;
      o.ir_write = rdy;
      o.pc_en    = rdy;
    end else if (st == S_MEM_READ) begin
      o.mem_read = 1'b1;
      o.i_or_d   = 1'b1;
    end else begin
      o.mem_write  = 1'b1;
      o.i_or_d     = 1'b1;
      o.instr_done = rdy;
    end
    return o;
  endfunction

  task automatic wait_phase(logic [3:0] st, int waits,
                            output bit dead);
    logic [6:0] op;
    int n;
    dead = 1'b0;
    n = (waits < WMAX) ? waits : WMAX;
    for (int i = 0; i < n; i++) begin
      op = (st == S_FETCH) ? 7'($urandom) : cur_op;
      put(1'b0, op, rb(), 1'b0, wait_obs(st, 1'b0));
    end
    if (waits >= WMAX) begin
      error_tail();
      dead = 1'b1;
    end else begin
      op = (st == S_FETCH) ? 7'($urandom) : cur_op;
      put(1'b0, op, rb(), 1'b1, wait_obs(st, 1'b1));
    end
  endtask

  task automatic instr(logic [6:0] op, int fw, int mw,
                       logic zbr, bit abort);
    bit   dead;
    obs_t e;
    cur_op = op;
    wait_phase(S_FETCH, fw, dead);
    if (dead) return;
    e = blank(S_DECODE);
    e.src_a = 2'b10;
    e.src_b = 2'b10;
    if (!(op inside {OP_LOAD, OP_STORE,
                     OP_RTYPE, OP_BRANCH})) begin
      e.illegal = 1'b1;
      put(1'b0, op, rb(), rb(), e);
      return;
    end
    put(1'b0, op, rb(), rb(), e);
    if (op == OP_RTYPE) begin
      e = blank(S_EXECUTE);
      e.src_a = 2'b01;
      e.aop   = 2'b10;
      put(1'b0, op, rb(), rb(), e);
      e = blank(S_ALU_WB);
      e.reg_write  = 1'b1;
      e.instr_done = 1'b1;
      put(1'b0, op, rb(), rb(), e);
    end else if (op == OP_BRANCH) begin
      e = blank(S_BRANCH);
      e.src_a      = 2'b01;
      e.aop        = 2'b01;
      e.pc_source  = 1'b1;
      e.instr_done = 1'b1;
      e.pc_en      = zbr;
      put(1'b0, op, zbr, rb(), e);
    end else begin
      e = blank(S_MEM_ADDR);
      e.src_a = 2'b01;
      e.src_b = 2'b10;
      put(1'b0, op, rb(), rb(), e);
      if (op == OP_LOAD) begin
        wait_phase(S_MEM_READ, mw, dead);
        if (dead) return;
        e = blank(S_MEM_WB);
        e.reg_write  = 1'b1;
        e.mem_to_reg = 1'b1;
        e.instr_done = 1'b1;
        put(1'b0, op, rb(), rb(), e);
      end else if (abort) begin
        put(1'b0, op, rb(), 1'b0,
            wait_obs(S_MEM_WRITE, 1'b0));
        reset_cyc();
      end else begin
        wait_phase(S_MEM_WRITE, mw, dead);
      end
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0)
      return 14 + $urandom_range(0, 3);
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 5))
      0: return OP_LOAD;
      1: return OP_STORE;
      2: return OP_BRANCH;
      3: return 7'($urandom);
      default: return OP_RTYPE;
    endcase
  endfunction

  // monitor: compare every cycle against the scoreboard
  always @(negedge clk) begin
    obs_t got, exp;
    if (scb.size() > 0) begin
      exp = scb.pop_front();
      got.st         = bus.state_o;
      got.pc_en      = bus.pc_en;
      got.ir_write   = bus.ir_write;
      got.mem_read   = bus.mem_read;
      got.mem_write  = bus.mem_write;
      got.i_or_d     = bus.i_or_d;
      got.reg_write  = bus.reg_write;
      got.mem_to_reg = bus.mem_to_reg;
      got.src_a      = bus.alu_src_a;
      got.src_b      = bus.alu_src_b;
      got.aop        = bus.alu_op;
      got.pc_source  = bus.pc_source;
      got.instr_done = bus.instr_done;
      got.illegal    = bus.illegal;
      got.err        = bus.err;
      n_chk++;
      if (got === exp) n_pass++;
      else
        $display("FAIL cyc%0d st%0d: got=%06h exp=%06h",
                 n_cyc, exp.st, got, exp);
      n_cyc++;
    end
  end

  initial begin
    cyc_t c;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    reset_cyc();
    reset_cyc();
    instr(OP_RTYPE,  0,  0, 1'b0, 1'b0);
    instr(OP_LOAD,   0,  3, 1'b0, 1'b0);
    instr(OP_BRANCH, 1,  0, 1'b1, 1'b0);
    instr(OP_BRANCH, 0,  0, 1'b0, 1'b0);
    instr(OP_STORE,  0,  2, 1'b0, 1'b0);
    instr(7'h7f,     0,  0, 1'b0, 1'b0);
    instr(OP_RTYPE,  16, 0, 1'b0, 1'b0);
    instr(OP_LOAD,   15, 0, 1'b0, 1'b0);
    instr(OP_LOAD,   0, 16, 1'b0, 1'b0);
    instr(OP_STORE,  0, 15, 1'b0, 1'b0);
    instr(OP_STORE,  0, 16, 1'b0, 1'b0);
    instr(OP_STORE,  0,  0, 1'b0, 1'b1);
    instr(OP_RTYPE,  0,  0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++)
      instr(pick_op(), pick_wait(), pick_wait(), rb(),
            ($urandom_range(0, 15) == 0));

    while (stim.size() > 0) begin
      c = stim.pop_front();
      @(posedge clk);
      #1;
      rst           = c.r;
      bus.opcode    = c.op;
      bus.zero      = c.z;
      bus.mem_ready = c.rdy;
      scb.push_back(c.e);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (scb.size() == 0) n_pass++;
    else $display("FAIL drain: left=%0d want=0",
                  scb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
